// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the intersection subsystem
//
// Contents:
//   presence_state_e : per-street presence FSM states (IDLE, PRESENT, HOLD)
//   GREEN/YELLOW/RED : light encodings consumed by the light FSM

package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    HOLD    = 2'b10
  } presence_state_e;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/sensor_channel.sv
// rtl/sensor_channel.sv - one detector channel: sync, debounce, car count, presence hold
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   raw      in   raw detector input, asynchronous to clk
//   cnt_clr  in   synchronous clear of the car counter (wins over increment)
//   present  out  traffic-present level, Moore decode of the presence FSM
//   cars     out  saturating count of debounced arrivals

module sensor_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             present,
  output logic [CNT_W-1:0] cars
);

  import traffic_pkg::*;

  // Counter widths never drop below one bit so degenerate parameters still elaborate.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   filt;
  logic [DB_W-1:0]        db_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   db_expire;
  logic                   filt_rise;
  presence_state_e        state;

  assign s = sync_q[SYNC_STAGES-1];

  // The filtered level flips only after s has disagreed with it for
  // DEBOUNCE_CYCLES consecutive edges, including the flipping edge itself.
  assign db_expire = (s != filt) && (db_cnt == DB_LAST);
  assign filt_rise = db_expire && s;

  // Synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debouncer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt   <= 1'b0;
      db_cnt <= '0;
    end else if (s == filt) begin
      db_cnt <= '0;
    end else if (db_expire) begin
      filt   <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Car counter: counts debounced arrivals, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cars <= '0;
    end else if (cnt_clr) begin
      cars <= '0;
    end else if (filt_rise && (cars != '1)) begin
      cars <= cars + 1'b1;
    end
  end

  // Presence FSM: stretches the filtered level so short gaps between
  // cars are not reported as an empty street.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (filt) begin
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (!filt) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (filt) begin
            state <= PRESENT;
          end else if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign present = (state != IDLE);

endmodule

// File: rtl/traffic_sensor_filter.sv
// rtl/traffic_sensor_filter.sv - conditions street A/B detectors into Ta/Tb and car counts
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   sa_raw   in   raw street-A detector, asynchronous
//   sb_raw   in   raw street-B detector, asynchronous
//   cnt_clr  in   synchronous clear of both car counters
//   Ta       out  street-A traffic present, to the light FSM
//   Tb       out  street-B traffic present, to the light FSM
//   cars_a   out  street-A debounced arrivals, saturating
//   cars_b   out  street-B debounced arrivals, saturating

module traffic_sensor_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             cnt_clr,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cars_a,
  output logic [CNT_W-1:0] cars_b
);

  sensor_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .raw     (sa_raw),
    .cnt_clr (cnt_clr),
    .present (Ta),
    .cars    (cars_a)
  );

  sensor_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .CNT_W           (CNT_W)
  ) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .raw     (sb_raw),
    .cnt_clr (cnt_clr),
    .present (Tb),
    .cars    (cars_b)
  );

endmodule

// File: tb/tb_traffic_sensor_filter.sv
// tb/tb_traffic_sensor_filter.sv - self-checking bench for traffic_sensor_filter

module tb_traffic_sensor_filter;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  logic sa_raw, sb_raw, cnt_clr;

  logic       ta_1, tb_1, ta_2, tb_2;
  logic [7:0] ca_1, cb_1;
  logic [1:0] ca_2, cb_2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  traffic_sensor_filter dut (
    .clk     (clk),
    .reset   (reset),
    .sa_raw  (sa_raw),
    .sb_raw  (sb_raw),
    .cnt_clr (cnt_clr),
    .Ta      (ta_1),
    .Tb      (tb_1),
    .cars_a  (ca_1),
    .cars_b  (cb_1)
  );

  traffic_sensor_filter #(.CNT_W(2)) dut_w2 (
    .clk     (clk),
    .reset   (reset),
    .sa_raw  (sa_raw),
    .sb_raw  (sb_raw),
    .cnt_clr (cnt_clr),
    .Ta      (ta_2),
    .Tb      (tb_2),
    .cars_a  (ca_2),
    .cars_b  (cb_2)
  );

  // Reference model: delay lines and sliding windows over per-edge history.
  bit raw_h  [2][SYNC];
  bit s_h    [2][DB];
  bit filt_h [2][HOLD+1];
  bit m_filt [2];
  bit m_t    [2];
  int m_c8   [2];
  int m_c2   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < SYNC; k++) raw_h[c][k] = 1'b0;
      for (int k = 0; k < DB; k++) s_h[c][k] = 1'b0;
      for (int k = 0; k <= HOLD; k++) filt_h[c][k] = 1'b0;
      m_filt[c] = 1'b0;
      m_t[c]    = 1'b0;
      m_c8[c]   = 0;
      m_c2[c]   = 0;
    end
  endtask

  task automatic model_edge(input int c, input bit raw, input bit clr);
    bit s_new, f_new, all_diff, any_f;
    for (int k = 0; k < SYNC-1; k++) raw_h[c][k] = raw_h[c][k+1];
    raw_h[c][SYNC-1] = raw;
    s_new = raw_h[c][0];
    // filt flips when the last DB synchronized values all disagree with it
    all_diff = 1'b1;
    for (int k = 0; k < DB; k++) if (s_h[c][k] == m_filt[c]) all_diff = 1'b0;
    f_new = all_diff ? !m_filt[c] : m_filt[c];
    for (int k = 0; k < DB-1; k++) s_h[c][k] = s_h[c][k+1];
    s_h[c][DB-1] = s_new;
    if (clr) begin
      m_c8[c] = 0;
      m_c2[c] = 0;
    end else if (f_new && !m_filt[c]) begin
      if (m_c8[c] < 255) m_c8[c]++;
      if (m_c2[c] < 3) m_c2[c]++;
    end
    // present if filt was high at any edge of the last HOLD+1 edges
    any_f = 1'b0;
    for (int k = 0; k <= HOLD; k++) if (filt_h[c][k]) any_f = 1'b1;
    m_t[c] = any_f;
    for (int k = 0; k < HOLD; k++) filt_h[c][k] = filt_h[c][k+1];
    filt_h[c][HOLD] = f_new;
    m_filt[c] = f_new;
  endtask

  task automatic check_all();
    chk("ta",       32'(ta_1), 32'(m_t[0]));
    chk("tb",       32'(tb_1), 32'(m_t[1]));
    chk("cars_a",   32'(ca_1), 32'(m_c8[0]));
    chk("cars_b",   32'(cb_1), 32'(m_c8[1]));
    chk("ta_w2",    32'(ta_2), 32'(m_t[0]));
    chk("tb_w2",    32'(tb_2), 32'(m_t[1]));
    chk("cars_a_w2", 32'(ca_2), 32'(m_c2[0]));
    chk("cars_b_w2", 32'(cb_2), 32'(m_c2[1]));
  endtask

  task automatic step(input bit a, input bit b, input bit clr);
    sa_raw  = a;
    sb_raw  = b;
    cnt_clr = clr;
    @(posedge clk);
    cyc++;
    model_edge(0, a, clr);
    model_edge(1, b, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    sa_raw = 1'b0; sb_raw = 1'b0; cnt_clr = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_ta", 32'(ta_1), 32'd0);
    chk("rst_tb", 32'(tb_1), 32'd0);
    chk("rst_ca", 32'(ca_1), 32'd0);
    chk("rst_cb", 32'(cb_1), 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  int  rem [2];
  bit  lvl [2];
  bit  held;

  initial begin
    sa_raw = 1'b0; sb_raw = 1'b0; cnt_clr = 1'b0; reset = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Glitch rejection
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(20);
    chk("glitch_cars_a", 32'(ca_1), 32'd0);

    // Single car: count at edge 6, Ta at edge 7, Ta falls 15 edges after raw fall
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 5) chk("single_cnt_e5", 32'(ca_1), 32'd0);
      if (i == 6) chk("single_cnt_e6", 32'(ca_1), 32'd1);
      if (i == 6) chk("single_ta_e6", 32'(ta_1), 32'd0);
      if (i == 7) chk("single_ta_e7", 32'(ta_1), 32'd1);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == 14) chk("single_fall_e14", 32'(ta_1), 32'd1);
      if (i == 15) chk("single_fall_e15", 32'(ta_1), 32'd0);
    end
    chk("single_tb", 32'(tb_1), 32'd0);
    chk("single_cb", 32'(cb_1), 32'd0);

    // Merged cars
    do_reset();
    held = 1'b0;
    for (int i = 0; i < 26; i++) begin
      step((i < 10) || (i >= 16), 1'b0, 1'b0);
      if (i >= 6) held = held | !ta_1;
    end
    chk("merged_gap", 32'(held), 32'd0);
    chk("merged_cars", 32'(ca_1), 32'd2);
    idle(25);

    // Saturation and clear on street B
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    end
    chk("sat_cb_w2", 32'(cb_2), 32'd3);
    chk("sat_cb", 32'(cb_1), 32'd5);
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, i == 6);
    chk("clr_cb_w2", 32'(cb_2), 32'd0);
    chk("clr_cb", 32'(cb_1), 32'd0);
    idle(25);

    // Reset mid-HOLD
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0);
    chk("hold_ta_before", 32'(ta_1), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ta", 32'(ta_1), 32'd0);
    chk("midrst_ca", 32'(ca_1), 32'd0);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 6) chk("post_rst_ta_e6", 32'(ta_1), 32'd0);
      if (i == 7) chk("post_rst_ta_e7", 32'(ta_1), 32'd1);
    end
    idle(25);

    // Independence: overlapping offset pulses
    for (int i = 0; i < 30; i++) step((i < 12), (i >= 5) && (i < 20), 1'b0);
    idle(25);

    // Randomized run-length stimulus
    rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = bit'($urandom_range(0, 1));
          rem[c] = int'($urandom_range(1, 14));
        end
        rem[c]--;
      end
      step(lvl[0], lvl[1], $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_filter.md
# traffic_sensor_filter

Upstream conditioning stage for the Moore traffic-light controller. It takes the two raw, asynchronous, bouncy vehicle-detector inputs for street A and street B and produces the clean, synchronous `Ta`/`Tb` traffic-present levels the light FSM consumes. It also keeps a saturating car count per street for status readout. Each channel is synchronized, debounced and then stretched by a hold timer, so the light FSM never sees a single-cycle gap between cars as "no traffic".

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; must be ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed before the filtered level changes; must be ≥1.
- `HOLD_CYCLES`, default 8: cycles `Ta`/`Tb` stay high after filtered traffic goes away; must be ≥1.
- `CNT_W`, default 8: car counter width.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sa_raw`  in  1  raw street-A detector, asynchronous to `clk`.
- `sb_raw`  in  1  raw street-B detector, asynchronous to `clk`.
- `cnt_clr`  in  1  synchronous clear of both car counters.
- `Ta`  out  1  street-A traffic present, to the light FSM.
- `Tb`  out  1  street-B traffic present, to the light FSM.
- `cars_a`  out  `CNT_W`  street-A debounced arrivals, saturating.
- `cars_b`  out  `CNT_W`  street-B debounced arrivals, saturating.

## Operation
The A and B channels are identical and fully independent. Each channel has the following pipeline.

- **Synchronizer:** a chain of `SYNC_STAGES` flops produces `s`.
- **Debouncer:** a register `filt` and a counter `db_cnt`.
  - If `s == filt`, `db_cnt` is cleared to 0.
  - Otherwise `db_cnt` increments each cycle.
  - On the edge where `s != filt` and `db_cnt == DEBOUNCE_CYCLES-1`, `filt <= s` and `db_cnt <= 0`.
  - Any return of `s` to `filt` before that edge clears `db_cnt`, so the glitch is discarded.
- **Car counter:** increments on the same edge where `filt` changes 0→1.
  - It saturates at all-ones and does not wrap.
  - `cnt_clr` forces the counter to 0. This wins over a coincident increment.
- **Presence FSM:** states IDLE, PRESENT, HOLD, with an ⌈log2(`HOLD_CYCLES`)⌉-bit `hold_cnt`.
  - IDLE → PRESENT when `filt == 1`.
  - PRESENT → HOLD when `filt == 0`; `hold_cnt <= HOLD_CYCLES-1`.
  - HOLD → PRESENT when `filt == 1`; the hold is aborted and `hold_cnt` is ignored.
  - HOLD → IDLE when `filt == 0` and `hold_cnt == 0`.
  - Otherwise HOLD stays in HOLD and `hold_cnt` decrements.
  - Output is Moore: `Ta` (or `Tb`) = `(state != IDLE)`, decoded directly from the state register.
- **Reset:** asserting `reset` asynchronously clears everything.
  - Synchronizer flops, `filt`, `db_cnt`, `hold_cnt` and counters go to 0; the FSM goes to IDLE.
  - So `Ta = Tb = 0` and `cars_a = cars_b = 0`.
  - This applies mid-operation too, with no partial state retained.

## Timing
Latencies below are counted in `clk` rising edges, with defaults in parentheses.

- **Raw rise to `s` rise:** `SYNC_STAGES` edges (2), counted from the first edge that samples the raw change.
- **`s` change to `filt` change:** `DEBOUNCE_CYCLES` edges (4), if `s` stays stable.
- **Raw rise to `Ta` rise:** `SYNC_STAGES + DEBOUNCE_CYCLES + 1` edges (7).
- **Car count:** increments `SYNC_STAGES + DEBOUNCE_CYCLES` edges (6) after the raw rise, one edge before `Ta` rises.
- **`filt` fall to `Ta` fall:** `HOLD_CYCLES + 1` edges (9). That is one edge to enter HOLD, then `HOLD_CYCLES` edges counting down.
- **Raw fall to `Ta` fall:** `SYNC_STAGES + DEBOUNCE_CYCLES + HOLD_CYCLES + 1` edges (15).
- **Raw pulse length:** a pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `filt`, `Ta` or the counter.
- **Gap merging:** a new `filt` rise during HOLD returns to PRESENT, so `Ta` stays high continuously. The car counter still increments for the new arrival.
- **Saturated counter:** further arrivals leave the value unchanged.
- **`cnt_clr`:** takes effect on the next edge. It does not affect `Ta`/`Tb`.

## Structure
- Shared package `traffic_pkg` holds:
  - the presence-FSM state enum `{IDLE, PRESENT, HOLD}`;
  - the light encoding constants used by the light FSM (GREEN=2'b00, YELLOW=2'b01, RED=2'b10), kept together for the intersection subsystem.
- One sub-module, `sensor_channel`, contains the synchronizer, debouncer, car counter and presence FSM. It carries the same parameters.
- The top level instantiates `sensor_channel` twice and only wires signals; it contains no logic of its own.

## Test plan
All scenarios use default parameters unless stated.
- **Glitch rejection:** `sa_raw` high for 3 cycles, then low → `Ta` stays 0 throughout; `cars_a` = 0.
- **Single car:** `sa_raw` high for 10 cycles.
  - `cars_a` becomes 1 six edges after the rise; `Ta` rises at edge 7.
  - `Ta` falls exactly 15 edges after `sa_raw` falls.
  - `Tb` and `cars_b` remain 0.
- **Merged cars:** `sa_raw` high 10 cycles, low 6 cycles, high 10 cycles → `Ta` never drops between the two cars; `cars_a` = 2.
- **Saturation and clear:** with `CNT_W = 2`, apply 5 debounced `sb_raw` pulses → `cars_b` reads 3 and stays at 3. Then assert `cnt_clr` in the same cycle as a 6th increment → `cars_b` = 0.
- **Reset mid-HOLD:** assert `reset` asynchronously while the channel is in HOLD with `Ta = 1` → `Ta` = 0 and `cars_a` = 0 immediately. After release, a 10-cycle pulse again yields `Ta` at edge 7.
- **Independence:** drive `sa_raw` and `sb_raw` with overlapping offset pulses → each output obeys its own latencies exactly, with no cross-coupling.
